// File: rtl/flappy_pkg.sv
// Shared state encoding, default geometry and the wrapping subtract for the
// Flappy-VGA obstacle scroller.
package flappy_pkg;
  typedef enum logic [2:0] {
    ST_INIT = 3'b001,
    ST_RUN  = 3'b010,
    ST_STOP = 3'b100
  } state_t;

  localparam int SCREEN_W   = 640;
  localparam int BIRD_X_DEF = 320;

  // Move left by speed; a pipe leaving past x=0 re-enters one full ring later.
  function automatic int wrap_sub(input int x, input int speed, input int wrap);
    if (x < speed) return x - speed + wrap;
    else           return x - speed;
  endfunction
endpackage

// File: rtl/pipe_lane.sv
// One pipe's left-edge register: reload in INIT, wrapping move on a tick.
module pipe_lane
  import flappy_pkg::*;
#(
  parameter int XW     = 11,
  parameter int INIT_X = 640,
  parameter int WRAP_X = 640
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic          i_move,
  input  logic [2:0]    i_speed,
  output logic [XW-1:0] o_x
);
  logic [XW-1:0] r_x;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)    r_x <= XW'(INIT_X);
    else if (i_load) r_x <= XW'(INIT_X);
    else if (i_move) r_x <= XW'(wrap_sub(int'(r_x), int'(i_speed), WRAP_X));

  assign o_x = r_x;
endmodule

// File: rtl/pipe_scroller.sv
// Horizontal pipe scroller: game FSM, head tracking, score/speed, and the
// head-first rotation of the pipe position registers.
module pipe_scroller #(
  parameter int NUM_PIPES  = 4,
  parameter int SPACING    = 160,
  parameter int PIPE_W     = 80,
  parameter int FIRST_X    = 640,
  parameter int BIRD_X     = 320,
  parameter int SPEED_INIT = 1,
  parameter int SPEED_MAX  = 4,
  parameter int LEVEL_PTS  = 8,
  parameter int SCORE_W    = 8,
  localparam int WRAP_X    = NUM_PIPES * SPACING,
  localparam int XW        = $clog2(FIRST_X + WRAP_X + PIPE_W + 1),
  localparam int IW        = $clog2(NUM_PIPES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    ack,
  input  logic                    pause,
  output logic [NUM_PIPES*XW-1:0] x_left,
  output logic [NUM_PIPES*XW-1:0] x_right,
  output logic [IW-1:0]           head_idx,
  output logic [SCORE_W-1:0]      score,
  output logic [2:0]              speed,
  output logic                    pass_pulse,
  output logic                    q_init,
  output logic                    q_run,
  output logic                    q_stop
);
  import flappy_pkg::*;

  localparam int LW = $clog2(LEVEL_PTS + 1);

  state_t                      r_state, w_next;
  logic [IW-1:0]               r_head;
  logic [SCORE_W-1:0]          r_score;
  logic [2:0]                  r_speed;
  logic [LW-1:0]               r_level;
  logic                        r_pass;
  logic [NUM_PIPES-1:0][XW-1:0] w_x;
  logic                        w_load, w_move, w_pass;
  logic [XW:0]                 w_head_r;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= ST_INIT;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT: if (start) w_next = ST_RUN;
      ST_RUN:  if (stop)  w_next = ST_STOP;
      ST_STOP: if (ack)   w_next = ST_INIT;
      default:            w_next = ST_INIT;
    endcase
  end

  always_comb begin
    q_init = (r_state == ST_INIT);
    q_run  = (r_state == ST_RUN);
    q_stop = (r_state == ST_STOP);
  end

  // stop wins over tick: the cycle that leaves RUN never moves
  assign w_load = (r_state == ST_INIT);
  assign w_move = (r_state == ST_RUN) && tick && !pause && !stop;

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_lane
    pipe_lane #(
      .XW    (XW),
      .INIT_X(FIRST_X + i * SPACING),
      .WRAP_X(WRAP_X)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .i_load (w_load),
      .i_move (w_move),
      .i_speed(r_speed),
      .o_x    (w_x[i])
    );
  end

  // Pass is judged on the pre-move head so only one pipe can pass per tick
  assign w_head_r = {1'b0, w_x[r_head]} + (XW+1)'(PIPE_W);
  assign w_pass   = w_move && (w_head_r < (XW+1)'(BIRD_X));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || w_load) begin
      r_head  <= '0;
      r_score <= '0;
      r_speed <= 3'(SPEED_INIT);
      r_level <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_pass <= w_pass;
      if (w_pass) begin
        r_head <= r_head + IW'(1);
        if (r_score != '1) r_score <= r_score + SCORE_W'(1);
        if (r_level == LW'(LEVEL_PTS - 1)) begin
          r_level <= '0;
          if (r_speed < 3'(SPEED_MAX)) r_speed <= r_speed + 3'd1;
        end else begin
          r_level <= r_level + LW'(1);
        end
      end
    end

  for (genvar k = 0; k < NUM_PIPES; k++) begin : g_rot
    logic [IW-1:0] w_idx;
    assign w_idx                   = r_head + IW'(k);
    assign x_left [k*XW +: XW]     = w_x[w_idx];
    assign x_right[k*XW +: XW]     = w_x[w_idx] + XW'(PIPE_W);
  end

  assign head_idx   = r_head;
  assign score      = r_score;
  assign speed      = r_speed;
  assign pass_pulse = r_pass;
endmodule
